ppu_nr_recip: RTL and testbench

Iterative Newton–Raphson mantissa reciprocal unit for the posit core's DIV path. It takes a normalised posit mantissa d in [1,2) and produces 1/d in fixed point at reciprocal precision (RMS = 2·MS bits), ready for the mantissa multiplier. It is a parametrised, sequential successor to the fixed-width reciprocal constants. Width follows N, iteration count is a parameter, and the unit uses a valid/ready handshake with one shared multiplier.

---
 rtl/ppu_nr_recip.sv | 131 +++++++++++++
 tb/tb_ppu_nr_recip.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_nr_recip.sv
// Iterative Newton-Raphson reciprocal of a normalised posit mantissa d in [1,2).
// One shared multiplier is time-multiplexed across the INIT, ITA and ITB states.
module ppu_nr_recip #(
  parameter int N     = 16,
  parameter int ITERS = 3
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [N-3:0]   mant_i,
  output logic           valid_o,
  input  logic           ready_i,
  output logic [2*N-5:0] recip_o,
  output logic           invalid_o,
  output logic           busy_o
);

  localparam int MS  = N - 2;
  localparam int RMS = 2 * MS;
  localparam int CW  = RMS + 8;
  // Product is pre-shifted by MS-1 so every stage slices from the same base.
  localparam int PW  = RMS + MS + 1;

  localparam logic [CW-1:0]  C0_FULL = (CW'(24) << (RMS - 1)) / CW'(17);
  localparam logic [CW-1:0]  C1_FULL = (CW'(8) << (RMS - 1)) / CW'(17);
  localparam logic [RMS-1:0] C0      = RMS'(C0_FULL);
  localparam logic [RMS-1:0] C1      = RMS'(C1_FULL);
  localparam logic [RMS-1:0] TWO     = {1'b1, {(RMS-1){1'b0}}};
  localparam logic [2:0]     LAST    = (ITERS == 0) ? 3'd0 : 3'(ITERS - 1);

  typedef enum logic [2:0] {IDLE, INIT, ITA, ITB, DONE} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      cnt_reg, cnt_next;
  logic [MS-1:0]   d_reg, d_next;
  logic [RMS-1:0]  x_reg, x_next;
  logic [RMS-1:0]  t_reg, t_next;
  logic            inv_reg, inv_next;
  logic [RMS-1:0]  recip_reg;
  logic            invalid_reg;

  logic [RMS-1:0]  mul_a, mul_b;
  logic [PW-1:0]   prod;

  assign mul_a = (state_reg == INIT) ? C1 : x_reg;
  assign mul_b = (state_reg == ITB) ? t_reg : {{(RMS-MS){1'b0}}, d_reg};
  assign prod  = PW'(({{RMS{1'b0}}, mul_a} * {{RMS{1'b0}}, mul_b}) >> (MS - 1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    d_next     = d_reg;
    x_next     = x_reg;
    t_next     = t_reg;
    inv_next   = inv_reg;
    case (state_reg)
      IDLE: begin
        if (valid_i) begin
          d_next     = mant_i;
          cnt_next   = 3'd0;
          state_next = INIT;
        end
      end
      INIT: begin
        if (!d_reg[MS-1]) begin
          x_next     = '0;
          inv_next   = 1'b1;
          state_next = DONE;
        end else begin
          x_next     = C0 - prod[0 +: RMS];
          inv_next   = 1'b0;
          state_next = (ITERS == 0) ? DONE : ITA;
        end
      end
      ITA: begin
        // e = d*x in Fx<2,RMS-2>; t = 2 - e wraps modulo 2^RMS
        t_next     = TWO - prod[1 +: RMS];
        state_next = ITB;
      end
      ITB: begin
        x_next     = (|prod[PW-1 -: 2]) ? '1 : prod[MS-1 +: RMS];
        cnt_next   = cnt_reg + 3'd1;
        state_next = (cnt_reg == LAST) ? DONE : ITA;
      end
      DONE: begin
        if (ready_i) begin
          if (valid_i) begin
            d_next     = mant_i;
            cnt_next   = 3'd0;
            state_next = INIT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      d_reg       <= '0;
      x_reg       <= '0;
      t_reg       <= '0;
      inv_reg     <= 1'b0;
      recip_reg   <= '0;
      invalid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      d_reg     <= d_next;
      x_reg     <= x_next;
      t_reg     <= t_next;
      inv_reg   <= inv_next;
      if (state_next == DONE) begin
        recip_reg   <= x_next;
        invalid_reg <= inv_next;
      end
    end
  end

  assign valid_o   = (state_reg == DONE);
  assign ready_o   = (state_reg == IDLE) || ((state_reg == DONE) && ready_i);
  assign busy_o    = (state_reg != IDLE);
  assign recip_o   = recip_reg;
  assign invalid_o = invalid_reg;

endmodule

// File: tb/tb_ppu_nr_recip.sv
// Directed bench for ppu_nr_recip at N=16, ITERS=3 (MS=14, RMS=28, tolerance 8 LSB).
module tb_ppu_nr_recip;

  localparam int TOL = 8;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        valid_i;
  logic        ready_o;
  logic [13:0] mant_i;
  logic        valid_o;
  logic        ready_i;
  logic [27:0] recip_o;
  logic        invalid_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  ppu_nr_recip #(.N(16), .ITERS(3)) dut (
    .clk_i    (clk),
    .rstn_i   (rstn_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .mant_i   (mant_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .recip_o  (recip_o),
    .invalid_o(invalid_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  // Hand-computed floor(2^27 / d) for the directed mantissas.
  logic [13:0] vec_m [4];
  logic [27:0] vec_e [4];

  function automatic longint absdiff(input logic [27:0] a, input logic [27:0] b);
    longint d;
    d = longint'(a) - longint'(b);
    return (d < 0) ? -d : d;
  endfunction

  // Stimulus only: present one input, wait (bounded) for valid_o.
  task automatic send(input logic [13:0] m, output int lat, output logic got);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b1;
    mant_i  = m;
    @(posedge clk);
    #1 valid_i = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      #1;
      if (valid_o) begin
        lat = i;
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rstn_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; mant_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", valid_o); end
    checks++; if (recip_o !== 28'h0) begin errors++; $display("FAIL rst_recip got=%h want=0", recip_o); end
    checks++; if (invalid_o !== 1'b0) begin errors++; $display("FAIL rst_invalid got=%b want=0", invalid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b want=1", ready_o); end
    @(negedge clk);
    rstn_i = 1'b1;
    $display("reset: valid=%b recip=%h invalid=%b busy=%b ready=%b", valid_o, recip_o, invalid_o, busy_o, ready_o);
  endtask

  task automatic test_normalised;
    int lat;
    logic got;
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(vec_m[k], lat, got);
      checks++;
      if (!got || lat != 7) begin
        errors++; $display("FAIL lat_%h got=%0d (seen=%b) want=7", vec_m[k], lat, got);
      end
      checks++;
      if (absdiff(recip_o, vec_e[k]) > TOL) begin
        errors++; $display("FAIL recip_%h got=%h want=%h+-%0d", vec_m[k], recip_o, vec_e[k], TOL);
      end
      checks++;
      if (invalid_o !== 1'b0) begin
        errors++; $display("FAIL inv_%h got=%b want=0", vec_m[k], invalid_o);
      end
      $display("norm: mant=%h lat=%0d recip=%h ideal=%h invalid=%b", vec_m[k], lat, recip_o, vec_e[k], invalid_o);
    end
  endtask

  task automatic test_invalid;
    int lat;
    logic got;
    ready_i = 1'b1;
    send(14'h1000, lat, got);
    checks++; if (!got || lat != 1) begin errors++; $display("FAIL inv_lat got=%0d (seen=%b) want=1", lat, got); end
    checks++; if (recip_o !== 28'h0) begin errors++; $display("FAIL inv_recip got=%h want=0", recip_o); end
    checks++; if (invalid_o !== 1'b1) begin errors++; $display("FAIL inv_flag got=%b want=1", invalid_o); end
    $display("invalid: mant=1000 lat=%0d recip=%h invalid=%b", lat, recip_o, invalid_o);
  endtask

  task automatic test_back_to_back;
    logic [13:0] bm [4];
    logic [27:0] be [4];
    int acc_cyc [4];
    int res_cyc [4];
    logic [27:0] res_val [4];
    int acc_idx, res_idx, cyc, bad_ready;
    logic accept;
    bm = '{14'h3800, 14'h2000, 14'h3FFF, 14'h3000};
    be = '{vec_e[3], vec_e[0], vec_e[2], vec_e[1]};
    acc_idx = 0; res_idx = 0; cyc = 0; bad_ready = 0;
    @(posedge clk);
    @(negedge clk);
    ready_i = 1'b1;
    valid_i = 1'b1;
    mant_i  = bm[0];
    while (cyc < 100 && res_idx < 4) begin
      if (valid_o) begin
        res_val[res_idx] = recip_o;
        res_cyc[res_idx] = cyc;
        res_idx++;
      end
      if (acc_idx > 0 && ready_o !== valid_o) bad_ready++;
      accept = valid_i && ready_o;
      if (accept && acc_idx < 4) acc_cyc[acc_idx] = cyc;
      @(posedge clk);
      #1;
      if (accept) begin
        acc_idx++;
        if (acc_idx < 4) mant_i = bm[acc_idx];
        else valid_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    valid_i = 1'b0;
    checks++;
    if (res_idx != 4) begin
      errors++; $display("FAIL b2b_count got=%0d want=4", res_idx);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (absdiff(res_val[i], be[i]) > TOL) begin
          errors++; $display("FAIL b2b_recip%0d got=%h want=%h+-%0d", i, res_val[i], be[i], TOL);
        end
        checks++;
        if (res_cyc[i] - acc_cyc[i] != 8) begin
          errors++; $display("FAIL b2b_lat%0d got=%0d want=8", i, res_cyc[i] - acc_cyc[i]);
        end
        if (i > 0) begin
          checks++;
          if (res_cyc[i] - res_cyc[i-1] != 8) begin
            errors++; $display("FAIL b2b_gap%0d got=%0d want=8", i, res_cyc[i] - res_cyc[i-1]);
          end
        end
        $display("b2b: idx=%0d mant=%h acc=%0d res=%0d recip=%h", i, bm[i], acc_cyc[i], res_cyc[i], res_val[i]);
      end
    end
    checks++;
    if (bad_ready != 0) begin
      errors++; $display("FAIL b2b_ready_pulse got=%0d bad cycles want=0", bad_ready);
    end
  endtask

  task automatic test_stall;
    int lat;
    logic got;
    logic [27:0] hold_val;
    int stable_bad, ready_bad;
    ready_i = 1'b0;
    send(14'h3000, lat, got);
    checks++; if (!got) begin errors++; $display("FAIL stall_seen got=0 want=1"); end
    hold_val = recip_o;
    checks++;
    if (absdiff(hold_val, vec_e[1]) > TOL) begin
      errors++; $display("FAIL stall_recip got=%h want=%h+-%0d", hold_val, vec_e[1], TOL);
    end
    stable_bad = 0; ready_bad = 0;
    @(negedge clk);
    valid_i = 1'b1;
    mant_i  = 14'h2000;
    repeat (20) begin
      @(negedge clk);
      if (valid_o !== 1'b1 || recip_o !== hold_val || invalid_o !== 1'b0) stable_bad++;
      if (ready_o !== 1'b0) ready_bad++;
    end
    checks++; if (stable_bad != 0) begin errors++; $display("FAIL stall_stable got=%0d unstable want=0", stable_bad); end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL stall_ready got=%0d high want=0", ready_bad); end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++; $display("FAIL stall_release got busy=%b valid=%b want 0/0", busy_o, valid_o);
    end
    $display("stall: recip=%h unstable=%0d ready_high=%0d busy_after=%b", hold_val, stable_bad, ready_bad, busy_o);
  endtask

  task automatic test_reset_midflight;
    int seen;
    ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b1;
    mant_i  = 14'h3FFF;
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn_i = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b want=0", valid_o); end
    checks++; if (recip_o !== 28'h0) begin errors++; $display("FAIL midrst_recip got=%h want=0", recip_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b want=1", ready_o); end
    @(negedge clk);
    rstn_i = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid_o !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_ghost got=%0d valid cycles want=0", seen); end
    $display("midrst: busy=%b recip=%h ghost_cycles=%0d", busy_o, recip_o, seen);
  endtask

  initial begin
    vec_m = '{14'h2000, 14'h3000, 14'h3FFF, 14'h3800};
    vec_e = '{28'h8000000, 28'h5555555, 28'h4001000, 28'h4924924};
    test_reset();
    test_normalised();
    test_invalid();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
